// File: rtl/mem_bus_master.sv
// Single-outstanding memory-bus initiator: core valid/ready request -> MAB/MDB/MW/BW access -> one-cycle response.
// Optional address-fault checking is enabled by defining MEM_BUS_FAULT_EN.
module mem_bus_master #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [15:0] MAB,
  output logic [15:0] MDB_out,
  input  logic [15:0] MDB_in,
  output logic        MW,
  output logic        BW
`ifdef MEM_BUS_FAULT_EN
  ,
  output logic        fault
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LP_WS = 3'(WAIT_STATES);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_byte;
  logic        r_odd;
  logic [2:0]  r_cnt;
  logic [15:0] r_mab;
  logic [15:0] r_mdb_out;
  logic [15:0] r_rdata;
  logic        w_accept;
  logic        w_last;
  logic        w_blocked;
  logic [15:0] w_aligned;
  logic [15:0] w_fmt;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_last    = (r_state == ACCESS) && (r_cnt == LP_WS);
  assign w_aligned = req_byte ? req_addr : {req_addr[15:1], 1'b0};

`ifdef MEM_BUS_FAULT_EN
  logic r_fault;

  function automatic logic f_addr_fault(input logic [15:0] a);
    f_addr_fault = ((a >= 16'h0400) && (a <= 16'hBFFF)) || (a == 16'hFFFF);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= f_addr_fault(w_aligned);
    end else begin
      r_fault <= r_fault;
    end
  end

  assign w_blocked = r_fault;
  assign fault     = (r_state == RESP) && r_fault;
`else
  assign w_blocked = 1'b0;
`endif

  // Read-data lane extraction; writes and blocked accesses return zero.
  always_comb begin
    w_fmt = 16'h0000;
    if (r_write || w_blocked) begin
      w_fmt = 16'h0000;
    end else if (r_byte) begin
      w_fmt = r_odd ? {8'h00, MDB_in[15:8]} : {8'h00, MDB_in[7:0]};
    end else begin
      w_fmt = MDB_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    MW         = 1'b0;
    BW         = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = ACCESS;
        end else begin
          w_next = IDLE;
        end
      end
      ACCESS: begin
        BW = r_byte;
        MW = r_write && w_last && !w_blocked;
        if (w_last) begin
          w_next = RESP;
        end else begin
          w_next = ACCESS;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request latching at acceptance, wait counting and read capture on the last ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write   <= 1'b0;
      r_byte    <= 1'b0;
      r_odd     <= 1'b0;
      r_cnt     <= 3'd0;
      r_mab     <= 16'h0000;
      r_mdb_out <= 16'h0000;
      r_rdata   <= 16'h0000;
    end else if (w_accept) begin
      r_write   <= req_write;
      r_byte    <= req_byte;
      r_odd     <= req_addr[0];
      r_cnt     <= 3'd0;
      r_mab     <= w_aligned;
      r_mdb_out <= req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        r_rdata <= w_fmt;
      end
    end
  end

  assign MAB        = r_mab;
  assign MDB_out    = r_mdb_out;
  assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: instances with WAIT_STATES 0, 3 and 2; fault checks when MEM_BUS_FAULT_EN is defined.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_write, req_byte;
  logic [15:0] req_addr, req_wdata, MDB_in;
  logic        valid_a, valid_b, valid_c;

  logic        ready_a, rv_a, mw_a, bw_a, fault_a;
  logic [15:0] rdata_a, mab_a, mdbo_a;
  logic        ready_b, rv_b, mw_b, bw_b, fault_b;
  logic [15:0] rdata_b, mab_b, mdbo_b;
  logic        ready_c, rv_c, mw_c, bw_c, fault_c;
  logic [15:0] rdata_c, mab_c, mdbo_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_master #(.WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rdata_a), .MAB(mab_a), .MDB_out(mdbo_a),
    .MDB_in(MDB_in), .MW(mw_a), .BW(bw_a)
`ifdef MEM_BUS_FAULT_EN
    , .fault(fault_a)
`endif
  );

  mem_bus_master #(.WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_rdata(rdata_b), .MAB(mab_b), .MDB_out(mdbo_b),
    .MDB_in(MDB_in), .MW(mw_b), .BW(bw_b)
`ifdef MEM_BUS_FAULT_EN
    , .fault(fault_b)
`endif
  );

  mem_bus_master #(.WAIT_STATES(2)) dut_c (
    .clk(clk), .rst(rst), .req_valid(valid_c), .req_ready(ready_c),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_c), .resp_rdata(rdata_c), .MAB(mab_c), .MDB_out(mdbo_c),
    .MDB_in(MDB_in), .MW(mw_c), .BW(bw_c)
`ifdef MEM_BUS_FAULT_EN
    , .fault(fault_c)
`endif
  );

`ifndef MEM_BUS_FAULT_EN
  assign fault_a = 1'b0;
  assign fault_b = 1'b0;
  assign fault_c = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    req_write = w;
    req_byte  = b;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Scramble request fields after acceptance; the DUT must use its latched copy.
  task automatic scramble();
    set_req(1'b1, 1'b0, 16'hDEAD, 16'hFFFF);
  endtask

  initial begin
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    MDB_in = 16'h0000;
    step();
    step();
    chk("rst_ready", {15'd0, ready_a}, 16'h0001);
    chk("rst_mw", {15'd0, mw_a}, 16'h0000);
    rst = 1'b0;
    step();
    chk("reset_ready", {15'd0, ready_a}, 16'h0001);
    chk("reset_resp_valid", {15'd0, rv_a}, 16'h0000);
    chk("reset_rdata", rdata_a, 16'h0000);
    chk("reset_mab", mab_a, 16'h0000);
    chk("reset_mdb_out", mdbo_a, 16'h0000);
    chk("reset_bw", {15'd0, bw_a}, 16'h0000);
    chk("reset_fault", {15'd0, fault_a}, 16'h0000);

    // WS=0 word write 0x1234 -> 0x0200
    set_req(1'b1, 1'b0, 16'h0200, 16'h1234);
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    chk("wr_access_mw", {15'd0, mw_a}, 16'h0001);
    chk("wr_access_mab", mab_a, 16'h0200);
    chk("wr_access_mdb", mdbo_a, 16'h1234);
    chk("wr_access_bw", {15'd0, bw_a}, 16'h0000);
    chk("wr_access_ready", {15'd0, ready_a}, 16'h0000);
    step();
    chk("wr_resp_valid", {15'd0, rv_a}, 16'h0001);
    chk("wr_resp_mw", {15'd0, mw_a}, 16'h0000);
    chk("wr_resp_rdata", rdata_a, 16'h0000);
    chk("wr_resp_mab_hold", mab_a, 16'h0200);
    step();
    chk("wr_idle_ready", {15'd0, ready_a}, 16'h0001);
    chk("wr_idle_rv", {15'd0, rv_a}, 16'h0000);

    // WS=0 word read 0x0200
    set_req(1'b0, 1'b0, 16'h0200, 16'h0000);
    MDB_in = 16'h1234;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    chk("rd_access_mw", {15'd0, mw_a}, 16'h0000);
    chk("rd_access_mab", mab_a, 16'h0200);
    chk("rd_access_rv", {15'd0, rv_a}, 16'h0000);
    step();
    chk("rd_resp_valid", {15'd0, rv_a}, 16'h0001);
    chk("rd_resp_rdata", rdata_a, 16'h1234);
    step();

    // Byte write 0xAB -> 0x0203
    set_req(1'b1, 1'b1, 16'h0203, 16'h55AB);
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    chk("bwr_bw", {15'd0, bw_a}, 16'h0001);
    chk("bwr_mdb", mdbo_a, 16'hABAB);
    chk("bwr_mab", mab_a, 16'h0203);
    chk("bwr_mw", {15'd0, mw_a}, 16'h0001);
    step();
    chk("bwr_resp_bw", {15'd0, bw_a}, 16'h0000);
    step();

    // Byte reads of odd and even lanes
    set_req(1'b0, 1'b1, 16'h0203, 16'h0000);
    MDB_in = 16'hAB12;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    chk("brd_odd_mab", mab_a, 16'h0203);
    step();
    chk("brd_odd_rdata", rdata_a, 16'h00AB);
    step();
    set_req(1'b0, 1'b1, 16'h0202, 16'h0000);
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    step();
    chk("brd_even_rv", {15'd0, rv_a}, 16'h0001);
    chk("brd_even_rdata", rdata_a, 16'h0012);
    step();

    // Word read of odd address forces alignment
    set_req(1'b0, 1'b0, 16'hC001, 16'h0000);
    MDB_in = 16'hBEEF;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    chk("odd_word_mab", mab_a, 16'hC000);
    step();
    chk("odd_word_rdata", rdata_a, 16'hBEEF);
    chk("odd_word_fault", {15'd0, fault_a}, 16'h0000);
    step();

    // WS=3 word read: only the last ACCESS cycle's MDB_in matters
    set_req(1'b0, 1'b0, 16'h0300, 16'h0000);
    valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    scramble();
    MDB_in = 16'h1111;
    chk("ws3_c1_ready", {15'd0, ready_b}, 16'h0000);
    chk("ws3_c1_mab", mab_b, 16'h0300);
    step();
    MDB_in = 16'h2222;
    chk("ws3_c2_rv", {15'd0, rv_b}, 16'h0000);
    step();
    MDB_in = 16'h3333;
    chk("ws3_c3_rv", {15'd0, rv_b}, 16'h0000);
    step();
    MDB_in = 16'h4444;
    chk("ws3_c4_rv", {15'd0, rv_b}, 16'h0000);
    step();
    MDB_in = 16'h9999;
    chk("ws3_t5_rv", {15'd0, rv_b}, 16'h0001);
    chk("ws3_t5_rdata", rdata_b, 16'h4444);
    chk("ws3_t5_ready", {15'd0, ready_b}, 16'h0000);
    step();
    chk("ws3_t6_ready", {15'd0, ready_b}, 16'h0001);
    chk("ws3_t6_rv", {15'd0, rv_b}, 16'h0000);
    chk("ws3_rdata_hold", rdata_b, 16'h4444);

    // WS=2 write aborted by reset in its strobe cycle
    set_req(1'b1, 1'b0, 16'h0100, 16'h7777);
    valid_c = 1'b1;
    step();
    valid_c = 1'b0;
    scramble();
    chk("abort_c1_mw", {15'd0, mw_c}, 16'h0000);
    step();
    chk("abort_c2_mw", {15'd0, mw_c}, 16'h0000);
    step();
    chk("abort_c3_mw", {15'd0, mw_c}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("abort_mw_async", {15'd0, mw_c}, 16'h0000);
    chk("abort_ready_async", {15'd0, ready_c}, 16'h0001);
    step();
    chk("abort_rv_in_rst", {15'd0, rv_c}, 16'h0000);
    rst = 1'b0;
    step();
    chk("abort_rv_after", {15'd0, rv_c}, 16'h0000);
    chk("abort_ready_after", {15'd0, ready_c}, 16'h0001);
    step();
    chk("abort_rv_after2", {15'd0, rv_c}, 16'h0000);

`ifdef MEM_BUS_FAULT_EN
    // Faulting write: no strobe, fault with resp_valid
    set_req(1'b1, 1'b0, 16'h0500, 16'hCAFE);
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    chk("fwr_mw", {15'd0, mw_a}, 16'h0000);
    chk("fwr_fault_early", {15'd0, fault_a}, 16'h0000);
    step();
    chk("fwr_rv", {15'd0, rv_a}, 16'h0001);
    chk("fwr_fault", {15'd0, fault_a}, 16'h0001);
    step();
    chk("fwr_fault_clear", {15'd0, fault_a}, 16'h0000);

    // Faulting byte read of 0xFFFF
    set_req(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    MDB_in = 16'h1234;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    step();
    chk("frd_rdata", rdata_a, 16'h0000);
    chk("frd_fault", {15'd0, fault_a}, 16'h0001);
    step();

    // Non-faulting read of 0x0200
    set_req(1'b0, 1'b0, 16'h0200, 16'h0000);
    MDB_in = 16'h5A5A;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    scramble();
    step();
    chk("nfrd_fault", {15'd0, fault_a}, 16'h0000);
    chk("nfrd_rdata", rdata_a, 16'h5A5A);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
